// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - slew-limited PWM duty controller with dead time and watchdog
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   setpoint   requested duty (signed), captured on sp_valid
//   sp_valid   setpoint strobe, also kicks the watchdog
//   enable     run request; low forces IDLE immediately
//   dty        duty to the PWM output stage (signed, registered)
//   pwm_enable enable to the PWM output stage (registered)
//   busy       high while in RAMP or DEAD (registered)
//   fault      latched watchdog trip (registered)
//   state      0=IDLE 1=RAMP 2=DEAD 3=HOLD 4=FAULT (registered)
module pwm_ramp_ctrl #(
  parameter int RAMP_DIV = 1000,
  parameter int STEP     = 1,
  parameter int DEADTIME = 16,
  parameter int DTY_MAX  = 255,
  parameter int WATCHDOG = 5000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [31:0] setpoint,
  input  logic               sp_valid,
  input  logic               enable,
  output logic signed [31:0] dty,
  output logic               pwm_enable,
  output logic               busy,
  output logic               fault,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RAMP  = 3'd1,
    S_DEAD  = 3'd2,
    S_HOLD  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic signed [31:0] STEP_S     = 32'(STEP);
  localparam logic signed [31:0] DMAX_S     = 32'(DTY_MAX);
  localparam logic        [31:0] PRESC_LAST = 32'(RAMP_DIV - 1);
  localparam logic        [31:0] WD_LIM     = 32'(WATCHDOG);
  localparam logic        [31:0] DEAD_LOAD  = 32'(DEADTIME);

  state_t             st;
  logic signed [31:0] target;
  logic signed [31:0] tgt_clamped;
  logic signed [31:0] diff;
  logic signed [31:0] dty_to_tgt;
  logic signed [31:0] dty_to_zero;
  logic signed [1:0]  lastdir;
  logic        [31:0] presc;
  logic        [31:0] dead_cnt;
  logic        [31:0] wd_cnt;
  logic               tick;
  logic               opposes;
  logic               active;
  logic               wd_expire;

  assign state = st;

  // Free-running prescaler; tick is high for the single cycle at the wrap value.
  assign tick = (presc == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (rst || tick) presc <= '0;
    else             presc <= presc + 32'd1;
  end

  always_comb begin
    tgt_clamped = setpoint;
    if (setpoint > DMAX_S)       tgt_clamped = DMAX_S;
    else if (setpoint < -DMAX_S) tgt_clamped = -DMAX_S;
  end

  always_ff @(posedge clk) begin
    if (rst)           target <= '0;
    else if (sp_valid) target <= tgt_clamped;
  end

  // One slew step toward target, landing exactly on it when within STEP.
  always_comb begin
    diff = target - dty;
    if (diff > STEP_S)       dty_to_tgt = dty + STEP_S;
    else if (diff < -STEP_S) dty_to_tgt = dty - STEP_S;
    else                     dty_to_tgt = target;
  end

  // One slew step toward zero, used while unwinding a direction reversal.
  always_comb begin
    if (dty > STEP_S)       dty_to_zero = dty - STEP_S;
    else if (dty < -STEP_S) dty_to_zero = dty + STEP_S;
    else                    dty_to_zero = '0;
  end

  // lastdir == 0 (nothing driven yet) never opposes; target == 0 never opposes.
  assign opposes = ((lastdir == 2'sd1) && (target < 0)) ||
                   ((lastdir == -2'sd1) && (target > 0));

  assign active = (st == S_RAMP) || (st == S_DEAD) || (st == S_HOLD);

  // A setpoint strobe in the same cycle rescues the controller from a trip.
  assign wd_expire = (WATCHDOG != 0) && active && !sp_valid && (wd_cnt >= WD_LIM);

  // Cleared on enable=0 as well so a fresh run does not inherit a stale count.
  always_ff @(posedge clk) begin
    if (rst || !enable || sp_valid) wd_cnt <= '0;
    else if (active && (wd_cnt != '1)) wd_cnt <= wd_cnt + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= S_IDLE;
      dty        <= '0;
      pwm_enable <= 1'b0;
      busy       <= 1'b0;
      fault      <= 1'b0;
      lastdir    <= 2'sd0;
      dead_cnt   <= '0;
    end else if (!enable) begin
      st         <= S_IDLE;
      dty        <= '0;
      pwm_enable <= 1'b0;
      busy       <= 1'b0;
      fault      <= 1'b0;
      dead_cnt   <= '0;
    end else if (wd_expire) begin
      st         <= S_FAULT;
      dty        <= '0;
      pwm_enable <= 1'b0;
      busy       <= 1'b0;
      fault      <= 1'b1;
      dead_cnt   <= '0;
    end else begin
      case (st)
        S_IDLE: begin
          if (!fault) begin
            st         <= S_RAMP;
            pwm_enable <= 1'b1;
            busy       <= 1'b1;
          end
        end

        S_RAMP: begin
          if (tick) begin
            if (opposes && (dty != 0)) begin
              dty <= dty_to_zero;
              if (dty_to_zero == 0) begin
                st       <= S_DEAD;
                dead_cnt <= DEAD_LOAD;
              end
            end else begin
              dty <= dty_to_tgt;
              if (dty_to_tgt != 0) lastdir <= dty_to_tgt[31] ? -2'sd1 : 2'sd1;
              if (dty_to_tgt == target) begin
                st   <= S_HOLD;
                busy <= 1'b0;
              end
            end
          end else if (dty == target) begin
            st   <= S_HOLD;
            busy <= 1'b0;
          end
        end

        // Output held at zero; runs to completion regardless of target.
        S_DEAD: begin
          dty <= '0;
          if (tick) begin
            if (dead_cnt <= 32'd1) begin
              dead_cnt <= '0;
              st       <= S_RAMP;
            end else begin
              dead_cnt <= dead_cnt - 32'd1;
            end
          end
        end

        S_HOLD: begin
          if (target != dty) begin
            st   <= S_RAMP;
            busy <= 1'b1;
          end
        end

        S_FAULT: begin
          dty        <= '0;
          pwm_enable <= 1'b0;
          busy       <= 1'b0;
          fault      <= 1'b1;
        end

        default: begin
          st         <= S_IDLE;
          dty        <= '0;
          pwm_enable <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
